// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes that reach the memory stage, the writeback bubble
// bundle, and the memory-stage FSM states.
package pipe_pkg;

  localparam logic [5:0]  OP_LOAD    = 6'b010000;
  localparam logic [5:0]  OP_STORE   = 6'b010001;
  localparam logic [63:0] NOP_BUNDLE = {3'b111, 29'b0, 3'b111, 29'b0};

  typedef enum logic {IDLE, WAIT} mem_state_t;

endpackage

// File: rtl/mem_lat_counter.sv
// Load/decrement counter timing the RAM read; o_last marks the cycle read data is valid.
// Latency: loaded value visible the cycle after i_load; no backpressure, free-running down to zero.
module mem_lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_last
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/mem_stage.sv
// Memory stage: upper-lane load/store against a fixed-latency RAM, both lanes registered to writeback.
// Latency 1 cycle for ALU/store, MEM_LAT+1 for loads; mem_stall holds execute while a load is outstanding.
module mem_stage
  import pipe_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ex_to_mem_ready,
  input  logic [63:0]       inst,
  input  logic [31:0]       u_tdata,
  input  logic [31:0]       l_tdata,
  input  logic [31:0]       u_sdata,
  input  logic [4:0]        u_rt,
  input  logic [4:0]        l_rt,
  input  logic              u_rt_flag,
  input  logic              l_rt_flag,
  output logic              mem_stall,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [63:0]       inst_to_wb,
  output logic [31:0]       u_wdata,
  output logic [31:0]       l_wdata,
  output logic [4:0]        u_rt_to_wb,
  output logic [4:0]        l_rt_to_wb,
  output logic              u_rt_flag_to_wb,
  output logic              l_rt_flag_to_wb
);

  mem_state_t  r_state;
  logic [63:0] r_hold_inst;
  logic [31:0] r_hold_l_data;
  logic [4:0]  r_hold_u_rt, r_hold_l_rt;
  logic        r_hold_u_flag, r_hold_l_flag;
  logic [63:0] r_inst_wb;
  logic [31:0] r_u_wdata, r_l_wdata;
  logic [4:0]  r_u_rt, r_l_rt;
  logic        r_u_flag, r_l_flag;

  logic w_idle, w_ld_issue, w_last, w_unused;

  // Strobes are qualified by rstn so nothing reaches the RAM or execute while held in reset.
  assign w_idle     = (r_state == IDLE);
  assign w_ld_issue = rstn & w_idle & ex_to_mem_ready;
  assign mem_re     = w_ld_issue;
  assign mem_we     = rstn & w_idle & ~ex_to_mem_ready & (inst[63:58] == OP_STORE);
  assign mem_stall  = w_ld_issue | (rstn & ~w_idle & ~w_last);
  assign mem_addr   = u_tdata[ADDR_W-1:0];
  assign mem_wdata  = u_sdata;
  assign w_unused   = &{1'b0, u_tdata[31:ADDR_W]};

  mem_lat_counter #(.CNT_W(4)) u_lat_cnt (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_load     (w_ld_issue),
    .i_load_val (4'(MEM_LAT)),
    .o_last     (w_last)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= IDLE;
      r_hold_inst   <= NOP_BUNDLE;
      r_hold_l_data <= '0;
      r_hold_u_rt   <= '0;
      r_hold_l_rt   <= '0;
      r_hold_u_flag <= 1'b0;
      r_hold_l_flag <= 1'b0;
      r_inst_wb     <= NOP_BUNDLE;
      r_u_wdata     <= '0;
      r_l_wdata     <= '0;
      r_u_rt        <= '0;
      r_l_rt        <= '0;
      r_u_flag      <= 1'b0;
      r_l_flag      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ex_to_mem_ready) begin
            r_state       <= WAIT;
            r_hold_inst   <= inst;
            r_hold_l_data <= l_tdata;
            r_hold_u_rt   <= u_rt;
            r_hold_l_rt   <= l_rt;
            r_hold_u_flag <= u_rt_flag;
            r_hold_l_flag <= l_rt_flag;
            r_inst_wb     <= NOP_BUNDLE;
            r_u_wdata     <= '0;
            r_l_wdata     <= '0;
            r_u_rt        <= '0;
            r_l_rt        <= '0;
            r_u_flag      <= 1'b0;
            r_l_flag      <= 1'b0;
          end else begin
            r_inst_wb <= inst;
            r_u_wdata <= u_tdata;
            r_l_wdata <= l_tdata;
            r_u_rt    <= u_rt;
            r_l_rt    <= l_rt;
            r_u_flag  <= u_rt_flag;
            r_l_flag  <= l_rt_flag;
          end
        end
        WAIT: begin
          // Execute only feeds bubbles here, so the input bundle is never looked at.
          if (w_last) begin
            r_state   <= IDLE;
            r_inst_wb <= r_hold_inst;
            r_u_wdata <= mem_rdata;
            r_l_wdata <= r_hold_l_data;
            r_u_rt    <= r_hold_u_rt;
            r_l_rt    <= r_hold_l_rt;
            r_u_flag  <= r_hold_u_flag;
            r_l_flag  <= r_hold_l_flag;
          end else begin
            r_inst_wb <= NOP_BUNDLE;
            r_u_wdata <= '0;
            r_l_wdata <= '0;
            r_u_rt    <= '0;
            r_l_rt    <= '0;
            r_u_flag  <= 1'b0;
            r_l_flag  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign inst_to_wb      = r_inst_wb;
  assign u_wdata         = r_u_wdata;
  assign l_wdata         = r_l_wdata;
  assign u_rt_to_wb      = r_u_rt;
  assign l_rt_to_wb      = r_l_rt;
  assign u_rt_flag_to_wb = r_u_flag;
  assign l_rt_flag_to_wb = r_l_flag;

endmodule
